// File: rtl/urv_lsu_writeback.sv
// urv_lsu_writeback: load/store unit and write-back stage of the uRV pipeline.
// Runs the data-memory handshake and extracts and extends load data. Detects bus errors,
// timeouts and misaligned accesses, and passes non-memory results straight to the register file.
// Optional: define URV_LSU_MISALIGN_SPLIT_EN so that a misaligned access crossing a bus-word
// boundary is carried out as two aligned transactions instead of faulting.
module urv_lsu_writeback #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              x_valid_i,
    input  logic              x_load_i,
    input  logic              x_store_i,
    input  logic [2:0]        x_fun_i,
    input  logic [XLEN-1:0]   x_dm_addr_i,
    input  logic [XLEN-1:0]   x_store_data_i,
    input  logic [4:0]        x_rd_i,
    input  logic [XLEN-1:0]   x_rd_value_i,
    input  logic              x_rd_write_i,
    output logic              dm_req_o,
    output logic              dm_we_o,
    output logic [XLEN-1:0]   dm_addr_o,
    output logic [XLEN/8-1:0] dm_be_o,
    output logic [XLEN-1:0]   dm_wdata_o,
    input  logic [XLEN-1:0]   dm_rdata_i,
    input  logic              dm_ack_i,
    input  logic              dm_err_i,
    output logic              w_stall_req_o,
    output logic [4:0]        rf_rd_o,
    output logic [XLEN-1:0]   rf_rd_value_o,
    output logic              rf_rd_write_o,
    output logic              w_fault_o,
    output logic [XLEN-1:0]   w_fault_addr_o
);
    localparam int unsigned NB = XLEN / 8;
    localparam int unsigned OW = $clog2(NB);

    typedef enum logic [2:0] {StIdle, StAccess, StAccessLo, StAccessHi, StDone} state_e;

    state_e          r_state;
    logic [XLEN-1:0] r_addr;        // original (possibly unaligned) address
    logic [XLEN-1:0] r_bus_addr;
    logic [NB-1:0]   r_be;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_rdata;
    logic [2:0]      r_fun;
    logic [4:0]      r_rd;
    logic            r_load;
    logic            r_we;
    logic            r_fault;
    logic [XLEN-1:0] r_fault_addr;
    logic [31:0]     r_cnt;

    logic            w_mem_op;
    logic            w_legal;
    logic            w_aligned;
    logic            w_in_access;
    logic            w_timeout;
    logic [OW-1:0]   w_off;
    logic [2:0]      w_amask;
    logic [7:0]      w_bmask8;
    logic [NB-1:0]   w_be;
    logic [XLEN-1:0] w_wdata_rep;
    logic [XLEN-1:0] w_base_addr;
    logic [XLEN-1:0] w_lane;
    logic [XLEN-1:0] w_load_val;

    // Decode the X-stage request: legality, alignment, lane enables and replicated store data.
    always_comb begin
        w_mem_op    = x_valid_i & (x_load_i | x_store_i);
        w_off       = x_dm_addr_i[OW-1:0];
        w_legal     = (x_fun_i != 3'b111) &&
                      ((XLEN == 64) || ((x_fun_i != 3'b011) && (x_fun_i != 3'b110)));
        case (x_fun_i[1:0])
            2'd0: begin
                w_amask     = 3'b000;
                w_bmask8    = 8'h01;
                w_wdata_rep = {NB{x_store_data_i[7:0]}};
            end
            2'd1: begin
                w_amask     = 3'b001;
                w_bmask8    = 8'h03;
                w_wdata_rep = {(NB/2){x_store_data_i[15:0]}};
            end
            2'd2: begin
                w_amask     = 3'b011;
                w_bmask8    = 8'h0f;
                w_wdata_rep = {(NB/4){x_store_data_i[31:0]}};
            end
            default: begin
                w_amask     = 3'b111;
                w_bmask8    = 8'hff;
                w_wdata_rep = x_store_data_i;
            end
        endcase
        w_aligned   = (x_dm_addr_i[2:0] & w_amask) == 3'b000;
        w_be        = w_bmask8[NB-1:0] << w_off;
        w_base_addr = {x_dm_addr_i[XLEN-1:OW], {OW{1'b0}}};
    end

`ifdef URV_LSU_MISALIGN_SPLIT_EN
    logic [NB-1:0]     r_be_hi;
    logic [XLEN-1:0]   r_wdata_hi;
    logic [XLEN-1:0]   r_rdata_hi;
    logic [XLEN-1:0]   w_data_sz;
    logic [2*NB-1:0]   w_be_wide;
    logic [2*XLEN-1:0] w_wdata_wide;
    logic              w_cross;

    // Misaligned stores need the data shifted into place over a two-word window, not replicated.
    always_comb begin
        case (x_fun_i[1:0])
            2'd0:    w_data_sz = XLEN'(x_store_data_i[7:0]);
            2'd1:    w_data_sz = XLEN'(x_store_data_i[15:0]);
            2'd2:    w_data_sz = XLEN'(x_store_data_i[31:0]);
            default: w_data_sz = x_store_data_i;
        endcase
        w_be_wide    = {{NB{1'b0}}, w_bmask8[NB-1:0]} << w_off;
        w_wdata_wide = {{XLEN{1'b0}}, w_data_sz} << {w_off, 3'b000};
        w_cross      = |w_be_wide[2*NB-1:NB];
    end
`endif

    // Pick the addressed lane out of the captured read data and extend it per size code.
    always_comb begin
`ifdef URV_LSU_MISALIGN_SPLIT_EN
        w_lane = XLEN'({r_rdata_hi, r_rdata} >> {r_addr[OW-1:0], 3'b000});
`else
        w_lane = r_rdata >> {r_addr[OW-1:0], 3'b000};
`endif
        case (r_fun)
            3'b000:  w_load_val = XLEN'($signed(w_lane[7:0]));
            3'b001:  w_load_val = XLEN'($signed(w_lane[15:0]));
            3'b010:  w_load_val = XLEN'($signed(w_lane[31:0]));
            3'b100:  w_load_val = XLEN'(w_lane[7:0]);
            3'b101:  w_load_val = XLEN'(w_lane[15:0]);
            3'b110:  w_load_val = XLEN'(w_lane[31:0]);
            default: w_load_val = w_lane;
        endcase
    end

    assign w_in_access = (r_state == StAccess) || (r_state == StAccessLo) ||
                         (r_state == StAccessHi);
    assign w_timeout   = (TIMEOUT_CYCLES != 0) && (r_cnt == TIMEOUT_CYCLES - 1);

    // Transaction FSM: latch the request, run the handshake(s), then spend one cycle in DONE.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= StIdle;
            r_addr       <= '0;
            r_bus_addr   <= '0;
            r_be         <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_fun        <= '0;
            r_rd         <= '0;
            r_load       <= 1'b0;
            r_we         <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_addr <= '0;
            r_cnt        <= '0;
`ifdef URV_LSU_MISALIGN_SPLIT_EN
            r_be_hi      <= '0;
            r_wdata_hi   <= '0;
            r_rdata_hi   <= '0;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_cnt <= '0;
                    if (w_mem_op) begin
                        r_addr     <= x_dm_addr_i;
                        r_bus_addr <= w_base_addr;
                        r_fun      <= x_fun_i;
                        r_rd       <= x_rd_i;
                        r_load     <= x_load_i;
                        r_we       <= ~x_load_i;
                        r_be       <= w_be;
                        r_wdata    <= w_wdata_rep;
                        r_fault    <= 1'b0;
                        if (w_legal && w_aligned) begin
                            r_state <= StAccess;
`ifdef URV_LSU_MISALIGN_SPLIT_EN
                        end else if (w_legal && !w_cross) begin
                            r_be    <= w_be_wide[NB-1:0];
                            r_wdata <= w_wdata_wide[XLEN-1:0];
                            r_state <= StAccess;
                        end else if (w_legal) begin
                            r_be       <= w_be_wide[NB-1:0];
                            r_wdata    <= w_wdata_wide[XLEN-1:0];
                            r_be_hi    <= w_be_wide[2*NB-1:NB];
                            r_wdata_hi <= w_wdata_wide[2*XLEN-1:XLEN];
                            r_state    <= StAccessLo;
`endif
                        end else begin
                            r_fault      <= 1'b1;
                            r_fault_addr <= x_dm_addr_i;
                            r_state      <= StDone;
                        end
                    end
                end
                StAccess, StAccessLo, StAccessHi: begin
                    r_cnt <= r_cnt + 32'd1;
                    if (dm_err_i || w_timeout) begin
                        r_fault      <= 1'b1;
                        r_fault_addr <= r_addr;
                        r_cnt        <= '0;
                        r_state      <= StDone;
                    end else if (dm_ack_i) begin
                        r_cnt <= '0;
`ifdef URV_LSU_MISALIGN_SPLIT_EN
                        if (r_state == StAccessLo) begin
                            r_rdata    <= dm_rdata_i;
                            r_be       <= r_be_hi;
                            r_wdata    <= r_wdata_hi;
                            r_bus_addr <= r_bus_addr + XLEN'(NB);
                            r_state    <= StAccessHi;
                        end else if (r_state == StAccessHi) begin
                            r_rdata_hi <= dm_rdata_i;
                            r_state    <= StDone;
                        end else begin
                            r_rdata <= dm_rdata_i;
                            r_state <= StDone;
                        end
`else
                        r_rdata <= dm_rdata_i;
                        r_state <= StDone;
`endif
                    end
                end
                default: begin
                    r_fault <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Bus, stall and register-file outputs; IDLE forwards non-memory results unregistered.
    always_comb begin
        dm_req_o       = w_in_access;
        dm_we_o        = w_in_access & r_we;
        dm_addr_o      = r_bus_addr;
        dm_be_o        = w_in_access ? r_be : '0;
        dm_wdata_o     = r_wdata;
        w_stall_req_o  = (w_mem_op && (r_state != StDone)) || w_in_access;
        w_fault_o      = (r_state == StDone) && r_fault;
        w_fault_addr_o = r_fault_addr;
        rf_rd_o        = '0;
        rf_rd_value_o  = '0;
        rf_rd_write_o  = 1'b0;
        if (r_state == StDone) begin
            rf_rd_o       = r_rd;
            rf_rd_value_o = w_load_val;
            rf_rd_write_o = r_load & ~r_fault;
        end else if (r_state == StIdle) begin
            rf_rd_o       = x_rd_i;
            rf_rd_value_o = x_rd_value_i;
            rf_rd_write_o = x_valid_i & x_rd_write_i & ~w_mem_op;
        end
    end
endmodule

// File: tb/tb_urv_lsu_writeback.sv
// Directed bench for urv_lsu_writeback: a 32-bit instance (short timeout) and a 64-bit instance.
module tb_urv_lsu_writeback;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        x_valid = 1'b0, x_load = 1'b0, x_store = 1'b0, x_rdw = 1'b0;
    logic [2:0]  x_fun = '0;
    logic [4:0]  x_rd = '0;
    logic [31:0] x_addr = '0, x_sdata = '0, x_rdval = '0, rdata = '0;
    logic        ack = 1'b0, err = 1'b0;
    logic        req, we, stall, rf_w, fault;
    logic [3:0]  be;
    logic [4:0]  rf_rd;
    logic [31:0] addr, wdata, rf_val, fault_addr;

    logic        x_valid6 = 1'b0, ack6 = 1'b0;
    logic [63:0] x_addr6 = '0, rdata6 = '0;
    logic        req6, we6, stall6, rf_w6, fault6;
    logic [7:0]  be6;
    logic [4:0]  rf_rd6;
    logic [63:0] addr6, wdata6, rf_val6, fault_addr6;

    int n_chk = 0;
    int n_err = 0;
    int n_req, n_stall, n_wr, n_flt;
    logic [31:0] last_val;

    always #5 clk = ~clk;

    urv_lsu_writeback #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .x_valid_i(x_valid), .x_load_i(x_load),
        .x_store_i(x_store), .x_fun_i(x_fun), .x_dm_addr_i(x_addr), .x_store_data_i(x_sdata),
        .x_rd_i(x_rd), .x_rd_value_i(x_rdval), .x_rd_write_i(x_rdw), .dm_req_o(req),
        .dm_we_o(we), .dm_addr_o(addr), .dm_be_o(be), .dm_wdata_o(wdata), .dm_rdata_i(rdata),
        .dm_ack_i(ack), .dm_err_i(err), .w_stall_req_o(stall), .rf_rd_o(rf_rd),
        .rf_rd_value_o(rf_val), .rf_rd_write_o(rf_w), .w_fault_o(fault),
        .w_fault_addr_o(fault_addr)
    );

    urv_lsu_writeback #(.XLEN(64), .TIMEOUT_CYCLES(255)) dut64 (
        .clk_i(clk), .rst_n_i(rst_n), .x_valid_i(x_valid6), .x_load_i(x_load),
        .x_store_i(x_store), .x_fun_i(x_fun), .x_dm_addr_i(x_addr6), .x_store_data_i(64'd0),
        .x_rd_i(x_rd), .x_rd_value_i(64'd0), .x_rd_write_i(x_rdw), .dm_req_o(req6),
        .dm_we_o(we6), .dm_addr_o(addr6), .dm_be_o(be6), .dm_wdata_o(wdata6),
        .dm_rdata_i(rdata6), .dm_ack_i(ack6), .dm_err_i(err), .w_stall_req_o(stall6),
        .rf_rd_o(rf_rd6), .rf_rd_value_o(rf_val6), .rf_rd_write_o(rf_w6), .w_fault_o(fault6),
        .w_fault_addr_o(fault_addr6)
    );

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  fun;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] val;
        logic        flt;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ld, input logic st, input logic [2:0] fun,
                         input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd);
        x_valid = 1'b1;
        x_load  = ld;
        x_store = st;
        x_fun   = fun;
        x_addr  = a;
        x_sdata = sd;
        x_rd    = 5'd9;
        x_rdw   = 1'b0;
        rdata   = rd;
    endtask

    task automatic run_vec(input int i, input vec_t v);
        string p;
        p = $sformatf("v%0d", i);
        @(negedge clk);
        drive(v.ld, v.st, v.fun, v.addr, v.sdata, v.rdata);
        #1 chk({p, "_stall"}, stall, 1);
        if (v.flt) begin
            @(negedge clk);
            x_valid = 1'b0;
            #1;
            chk({p, "_fault"}, fault, 1);
            chk({p, "_noreq"}, req, 0);
            chk({p, "_nowr"}, rf_w, 0);
            chk({p, "_faddr"}, fault_addr, v.addr);
        end else begin
            @(negedge clk);
            #1;
            chk({p, "_req"}, req, 1);
            chk({p, "_addr"}, addr, {v.addr[31:2], 2'b00});
            chk({p, "_be"}, be, v.be);
            chk({p, "_we"}, we, v.st);
            if (v.st) chk({p, "_wdata"}, wdata, v.wdata);
            ack = 1'b1;
            @(negedge clk);
            ack = 1'b0;
            x_valid = 1'b0;
            #1;
            chk({p, "_wr"}, rf_w, v.ld);
            chk({p, "_nofault"}, fault, 0);
            if (v.ld) begin
                chk({p, "_val"}, rf_val, v.val);
                chk({p, "_rd"}, rf_rd, 9);
            end
        end
        @(negedge clk);
        #1 chk({p, "_idle_req"}, req, 0);
    endtask

    task automatic run64(input string p, input logic [2:0] fun, input logic [63:0] a,
                         input logic [63:0] rd, input logic [7:0] e_be, input logic [63:0] e_val);
        @(negedge clk);
        x_valid6 = 1'b1;
        x_load   = 1'b1;
        x_store  = 1'b0;
        x_fun    = fun;
        x_addr6  = a;
        rdata6   = rd;
        #1 chk({p, "_stall"}, stall6, 1);
        @(negedge clk);
        #1;
        chk({p, "_req"}, req6, 1);
        chk({p, "_be"}, be6, e_be);
        chk({p, "_addr"}, addr6, {a[63:3], 3'b000});
        ack6 = 1'b1;
        @(negedge clk);
        ack6 = 1'b0;
        x_valid6 = 1'b0;
        #1;
        chk({p, "_wr"}, rf_w6, 1);
        chk({p, "_val"}, rf_val6, e_val);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          ld    st    fun     addr      sdata         rdata         be       wdata         val           flt
        vecs[0]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0,        32'h80000000, 4'b1000, 32'h0,        32'hFFFFFF80, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 3'b100, 32'h101, 32'h0,        32'h0000F100, 4'b0010, 32'h0,        32'h000000F1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0,        32'h80010000, 4'b1100, 32'h0,        32'hFFFF8001, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 3'b101, 32'h100, 32'h0,        32'h00009ABC, 4'b0011, 32'h0,        32'h00009ABC, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 3'b010, 32'h104, 32'h0,        32'hDEADBEEF, 4'b1111, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 3'b000, 32'h102, 32'hA5,       32'h0,        4'b0100, 32'hA5A5A5A5, 32'h0,        1'b0};
        vecs[6]  = '{1'b0, 1'b1, 3'b001, 32'h102, 32'h1234,     32'h0,        4'b1100, 32'h12341234, 32'h0,        1'b0};
        vecs[7]  = '{1'b0, 1'b1, 3'b010, 32'h108, 32'hCAFEF00D, 32'h0,        4'b1111, 32'hCAFEF00D, 32'h0,        1'b0};
        vecs[8]  = '{1'b0, 1'b1, 3'b000, 32'h107, 32'hFFFFFF3C, 32'h0,        4'b1000, 32'h3C3C3C3C, 32'h0,        1'b0};
        vecs[9]  = '{1'b0, 1'b1, 3'b001, 32'h100, 32'hABCD5678, 32'h0,        4'b0011, 32'h56785678, 32'h0,        1'b0};
        vecs[10] = '{1'b1, 1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1'b1};
        vecs[11] = '{1'b1, 1'b0, 3'b111, 32'h104, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1'b1};
        vecs[12] = '{1'b1, 1'b0, 3'b110, 32'h10C, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1'b1};
        vecs[13] = '{1'b1, 1'b0, 3'b001, 32'h106, 32'h0,        32'h7FFF0000, 4'b1100, 32'h0,        32'h00007FFF, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 3'b011, 32'h108, 32'h55,       32'h0,        4'b0000, 32'h0,        32'h0,        1'b1};

        // Reset state
        #2;
        chk("rst_req", req, 0);
        chk("rst_stall", stall, 0);
        chk("rst_fault", fault, 0);
        chk("rst_faddr", fault_addr, 0);
        chk("rst_be", be, 0);
        chk("rst_we", we, 0);
        chk("rst_wr", rf_w, 0);
        chk("rst_req64", req6, 0);
        #20 rst_n = 1'b1;

        // Non-memory pass-through
        @(negedge clk);
        x_valid = 1'b1; x_rdw = 1'b1; x_rd = 5'd7; x_rdval = 32'h55AA_1234;
        #1;
        chk("pass_wr", rf_w, 1);
        chk("pass_rd", rf_rd, 7);
        chk("pass_val", rf_val, 32'h55AA_1234);
        chk("pass_stall", stall, 0);
        chk("pass_req", req, 0);
        @(negedge clk);
        x_valid = 1'b0;
        #1 chk("pass_invalid_wr", rf_w, 0);
        x_rdw = 1'b0;

        for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

        // LB with ack on the third ACCESS cycle: stall and write-back pulse lengths
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80000000);
        n_req = 0; n_stall = 0; n_wr = 0; last_val = '0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (stall) n_stall++;
            if (req) n_req++;
            if (rf_w) begin
                n_wr++;
                last_val = rf_val;
                x_valid = 1'b0;
            end
            ack = req && (n_req == 3);
            @(negedge clk);
        end
        ack = 1'b0;
        chk("lb_stall_cycles", n_stall, 4);
        chk("lb_req_cycles", n_req, 3);
        chk("lb_wr_cycles", n_wr, 1);
        chk("lb_val", last_val, 32'hFFFFFF80);

        // Misaligned LW at 0x101
`ifdef URV_LSU_MISALIGN_SPLIT_EN
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'hDDCCBBAA);
        #1 chk("split_stall", stall, 1);
        @(negedge clk);
        #1;
        chk("split_lo_req", req, 1);
        chk("split_lo_addr", addr, 32'h100);
        chk("split_lo_be", be, 4'b1110);
        ack = 1'b1;
        @(negedge clk);
        rdata = 32'h00000011;
        #1;
        chk("split_hi_req", req, 1);
        chk("split_hi_addr", addr, 32'h104);
        chk("split_hi_be", be, 4'b0001);
        @(negedge clk);
        ack = 1'b0; x_valid = 1'b0;
        #1;
        chk("split_wr", rf_w, 1);
        chk("split_val", rf_val, 32'h11DDCCBB);
        chk("split_nofault", fault, 0);
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 32'h00ABCD00);
        @(negedge clk);
        #1;
        chk("inword_req", req, 1);
        chk("inword_addr", addr, 32'h100);
        chk("inword_be", be, 4'b0110);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0; x_valid = 1'b0;
        #1;
        chk("inword_wr", rf_w, 1);
        chk("inword_val", rf_val, 32'hFFFFABCD);
`else
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h0);
        #1 chk("mis_req0", req, 0);
        @(negedge clk);
        x_valid = 1'b0;
        #1;
        chk("mis_fault", fault, 1);
        chk("mis_req1", req, 0);
        chk("mis_wr", rf_w, 0);
        chk("mis_faddr", fault_addr, 32'h101);
        @(negedge clk);
        #1;
        chk("mis_fault_pulse", fault, 0);
        chk("mis_faddr_hold", fault_addr, 32'h101);
`endif

        // Timeout after 4 ACCESS cycles without ack
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h0);
        n_req = 0; n_flt = 0; n_wr = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (req) n_req++;
            if (rf_w) n_wr++;
            if (fault) begin
                n_flt++;
                x_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("to_req_cycles", n_req, 4);
        chk("to_fault_pulses", n_flt, 1);
        chk("to_wr", n_wr, 0);
        chk("to_faddr", fault_addr, 32'h100);

        // Error and ack together
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b010, 32'h10C, 32'h0, 32'h12345678);
        @(negedge clk);
        #1 chk("err_req", req, 1);
        ack = 1'b1; err = 1'b1;
        @(negedge clk);
        ack = 1'b0; err = 1'b0; x_valid = 1'b0;
        #1;
        chk("err_fault", fault, 1);
        chk("err_wr", rf_w, 0);
        chk("err_faddr", fault_addr, 32'h10C);

        // Reset in the middle of ACCESS
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 32'h0);
        @(negedge clk);
        #1 chk("rstmid_req_before", req, 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_req_async", req, 0);
        chk("rstmid_fault", fault, 0);
        chk("rstmid_wr", rf_w, 0);
        x_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        x_valid = 1'b1; x_load = 1'b0; x_store = 1'b0; x_rdw = 1'b1; x_rd = 5'd3;
        x_rdval = 32'h77;
        #1;
        chk("rstmid_idle_wr", rf_w, 1);
        chk("rstmid_idle_stall", stall, 0);
        chk("rstmid_idle_req", req, 0);
        @(negedge clk);
        x_valid = 1'b0; x_rdw = 1'b0;
        run_vec(100, vecs[4]);

        // 64-bit datapath
        run64("lwu64", 3'b110, 64'h104, 64'h89ABCDEF_00000000, 8'hF0, 64'h00000000_89ABCDEF);
        run64("lw64", 3'b010, 64'h104, 64'h89ABCDEF_00000000, 8'hF0, 64'hFFFFFFFF_89ABCDEF);
        run64("ld64", 3'b011, 64'h108, 64'h01234567_89ABCDEF, 8'hFF, 64'h01234567_89ABCDEF);
        run64("lhu64", 3'b101, 64'h10E, 64'hBEEF0000_00000000, 8'hC0, 64'h00000000_0000BEEF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/urv_lsu_writeback.md
Name: urv_lsu_writeback

Overview:
- Parametrised successor of the uRV write-back stage.
- Owns the data-memory transaction: request/ack handshake, byte-enable and store-lane generation, load extraction and extension, bus-error and timeout detection, and misaligned-access handling.
- Sits between the execute stage (X) and the register file.
- Stalls X while a memory access is in flight. Non-memory results pass straight through.

Parameters:
- XLEN, 32: datapath width; legal values 32 or 64.
- TIMEOUT_CYCLES, 255: ACCESS cycles allowed without ack/err before a fault; 0 disables the timeout.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- x_valid_i  in  1  X stage holds a valid instruction.
- x_load_i  in  1  instruction is a load.
- x_store_i  in  1  instruction is a store.
- x_fun_i  in  3  size code: B=000, H=001, W=010, D=011, BU=100, HU=101, WU=110.
- x_dm_addr_i  in  XLEN  effective address.
- x_store_data_i  in  XLEN  store data, right-aligned.
- x_rd_i  in  5  destination register.
- x_rd_value_i  in  XLEN  non-memory result.
- x_rd_write_i  in  1  non-memory result writes rd.
- dm_req_o  out  1  bus request.
- dm_we_o  out  1  write (1) or read (0).
- dm_addr_o  out  XLEN  address, aligned to XLEN/8 bytes.
- dm_be_o  out  XLEN/8  byte enables.
- dm_wdata_o  out  XLEN  lane-positioned write data.
- dm_rdata_i  in  XLEN  read data.
- dm_ack_i  in  1  transaction complete.
- dm_err_i  in  1  bus error.
- w_stall_req_o  out  1  hold X stage.
- rf_rd_o  out  5  register-file write index.
- rf_rd_value_o  out  XLEN  register-file write data.
- rf_rd_write_o  out  1  register-file write enable.
- w_fault_o  out  1  one-cycle fault pulse.
- w_fault_addr_o  out  XLEN  faulting address; holds its value until the next fault.

Behaviour:
- Reset values: state IDLE; all outputs 0; timeout counter 0. Asserting reset mid-access drops dm_req_o immediately, with no write-back and no fault.
- Memory op = x_valid_i & (x_load_i | x_store_i). Non-memory ops in IDLE:
  - rf_* driven combinationally from x_rd_i / x_rd_value_i.
  - rf_rd_write_o = x_valid_i & x_rd_write_i.
  - w_stall_req_o = 0.
- Codes D and WU are legal only when XLEN=64. Otherwise (and for code 111) the access is treated as misaligned.
- Alignment rules:
  - H needs addr[0]=0.
  - W needs addr[1:0]=0.
  - D needs addr[2:0]=0.
- FSM:
  - IDLE: on an aligned memory op, latch addr/fun/rd/load/wdata/be and go to ACCESS. On a misaligned op, go to DONE with the fault flag set and no bus activity.
  - ACCESS: dm_req_o=1; dm_addr_o, dm_we_o, dm_be_o and dm_wdata_o stay stable. The counter increments each cycle.
    - dm_err_i, or counter reaching TIMEOUT_CYCLES: fault flag set, go to DONE.
    - Otherwise dm_ack_i: capture dm_rdata_i, go to DONE.
    - dm_err_i wins when asserted together with dm_ack_i.
    - dm_req_o deasserts in the cycle after ack/err.
  - DONE (1 cycle):
    - Load without fault: rf_rd_write_o=1; rf_rd_value_o is the extracted lane, sign- or zero-extended per fun, from the registered capture.
    - Store, or any fault: rf_rd_write_o=0.
    - Fault: w_fault_o=1 and w_fault_addr_o = latched address.
    - Go to IDLE.
- w_stall_req_o = (memory op & state≠DONE) | state==ACCESS. A memory op therefore completes in ≥3 cycles, and X advances on the DONE cycle.
- Store lanes: the data byte is replicated across every lane of its size; dm_be_o selects the lanes at the address offset.

Optional Feature:
- URV_LSU_MISALIGN_SPLIT_EN defined: a misaligned B/H/W/D access that crosses an XLEN/8 boundary becomes two aligned accesses.
  - Extra states ACCESS_LO → ACCESS_HI, each a full handshake; the timeout counter resets between them.
  - Loads merge both captures before DONE.
  - A fault in either half aborts the access. No rf write occurs; a store whose first half was already written is not rolled back. w_fault_addr_o = original address.
  - An access misaligned but within one word is done in a single transaction.
  - Illegal size codes still fault.
- Macro undefined: every misaligned access faults as described above.

Test Plan:
- XLEN=32, LB addr=0x103, dm_rdata_i=0x80_00_00_00, ack after 2 cycles → rf_rd_value_o=0xFFFFFF80, rf_rd_write_o=1 for exactly 1 cycle, stall high for 4 cycles.
- SH addr=0x102, data=0x1234 → dm_be_o=1100, dm_wdata_o=0x12341234, dm_we_o=1, rf_rd_write_o=0.
- LW addr=0x101, split macro off → no dm_req_o, w_fault_o=1, w_fault_addr_o=0x101. Split macro on, rdata 0xDDCCBBAA then 0x00000011 → two requests (0x100, 0x104), result 0x11DDCCBB.
- TIMEOUT_CYCLES=4, no ack → dm_req_o high 4 cycles then drops, w_fault_o=1, no rf write.
- dm_err_i and dm_ack_i together → fault, no rf write. rst_n_i low mid-ACCESS → dm_req_o=0 asynchronously, and after release the FSM is in IDLE.
- XLEN=64, LWU addr=0x104, rdata=0x89ABCDEF_00000000 → rf_rd_value_o=0x0000000089ABCDEF.
